// File: rtl/booth_mul_arbiter.sv
// booth_mul_arbiter: round-robin sharing of one signed Booth multiplier among NREQ clients.
// Optional WAIT-state watchdog: define BOOTH_ARB_TIMEOUT_EN to enable it.

module booth_mul_arbiter #(
  parameter int NREQ       = 4,
  parameter int WIDTH      = 5,
  parameter int TMO_CYCLES = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*WIDTH-1:0]   opa,
  input  logic [NREQ*WIDTH-1:0]   opb,
  output logic [NREQ-1:0]         gnt,
  output logic [NREQ-1:0]         rsp_valid,
  output logic [2*WIDTH-1:0]      rsp_data,
  output logic                    rsp_err,
  output logic                    busy,
  output logic                    mul_start,
  output logic [WIDTH-1:0]        mul_inbus,
  input  logic                    mul_ready,
  input  logic                    mul_done,
  input  logic [2*WIDTH-1:0]      mul_result,
  output logic [2:0]              state_dbg
);

  // Handshakes: a client holds req and its operands until its one-cycle gnt pulse.
  // A job is accepted only in IDLE with mul_ready=1; mul_start carries X, the next
  // cycle carries Y, and the multiplier answers with a mul_done pulse in WAIT.

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_LOADY = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_RESP  = 3'd4;

  if (NREQ < 2 || NREQ > 8 || TMO_CYCLES < 1 || TMO_CYCLES > 65535) begin : g_bad_params
    $error("booth_mul_arbiter: parameter out of range");
  end

  logic [2:0]         state;
  logic [IW-1:0]      ptr;
  logic [IW-1:0]      idx;
  logic [IW-1:0]      win;
  logic [IW-1:0]      cand;
  logic               found;
  logic [WIDTH-1:0]   xq;
  logic [WIDTH-1:0]   yq;
  logic [2*WIDTH-1:0] prod_q;
  logic [NREQ-1:0]    onehot;
  logic               tmo_hit;

  // First asserted request at or after the pointer, wrapping around.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = (int'(ptr) + k >= NREQ) ? IW'(int'(ptr) + k - NREQ) : IW'(int'(ptr) + k);
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= S_IDLE;
      ptr    <= '0;
      idx    <= '0;
      xq     <= '0;
      yq     <= '0;
      prod_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (found && mul_ready) begin
            idx   <= win;
            xq    <= opa[win*WIDTH +: WIDTH];
            yq    <= opb[win*WIDTH +: WIDTH];
            state <= S_START;
          end
        end
        S_START: begin
          ptr   <= (idx == IW'(NREQ - 1)) ? '0 : idx + IW'(1);
          state <= S_LOADY;
        end
        S_LOADY: state <= S_WAIT;
        S_WAIT: begin
          if (mul_done) begin
            prod_q <= mul_result;
            state  <= S_RESP;
          end else if (tmo_hit) begin
            prod_q <= '0;
            state  <= S_RESP;
          end
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef BOOTH_ARB_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TMO_CYCLES - 1);

  logic [15:0] tmo_cnt;
  logic        err_q;

  // Counter reads 0 in the first WAIT cycle, so the abort lands after TMO_CYCLES WAIT cycles.
  assign tmo_hit = (tmo_cnt == TMO_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_cnt <= '0;
      err_q   <= 1'b0;
    end else if (state == S_LOADY) begin
      tmo_cnt <= '0;
      err_q   <= 1'b0;
    end else if (state == S_WAIT && !mul_done) begin
      tmo_cnt <= tmo_cnt + 16'd1;
      if (tmo_hit) err_q <= 1'b1;
    end
  end

  assign rsp_err = (state == S_RESP) && err_q;
`else
  assign tmo_hit = 1'b0;
  assign rsp_err = 1'b0;
`endif

  // Outputs decode only registered state, so nothing combinational runs from req to gnt.
  always_comb begin
    onehot      = '0;
    onehot[idx] = 1'b1;
    gnt         = (state == S_START) ? onehot : '0;
    rsp_valid   = (state == S_RESP) ? onehot : '0;
    rsp_data    = (state == S_RESP) ? prod_q : '0;
    mul_start   = (state == S_START);
    busy        = (state != S_IDLE);
    mul_inbus   = '0;
    if (state == S_START) mul_inbus = xq;
    if (state == S_LOADY) mul_inbus = yq;
  end

  assign state_dbg = state;

endmodule

// File: doc/booth_mul_arbiter.md
Name: booth_mul_arbiter

Overview:
- Shares one signed Booth multiplier (5-bit operands, 10-bit product) among NREQ requesters.
- Per job: picks a requester round-robin, latches its operand pair and starts the multiplier.
- Serialises X then Y onto the multiplier input bus, waits for done, then returns the product to the granted requester.
- Sits between the requester clients and a single multiplier instance.

Parameters:
- NREQ, 4, number of requesters (2..8)
- WIDTH, 5, operand width; product is 2*WIDTH
- TMO_CYCLES, 64, watchdog limit in WAIT state (used only with the optional feature)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- req  in  NREQ  per-requester request level
- opa  in  NREQ*WIDTH  X operands, requester i at [i*WIDTH +: WIDTH]
- opb  in  NREQ*WIDTH  Y operands, same packing
- gnt  out  NREQ  one-hot, one-cycle pulse: operands of that requester captured
- rsp_valid  out  NREQ  one-hot, one-cycle pulse: result ready for that requester
- rsp_data  out  2*WIDTH  product, valid while any rsp_valid bit is 1
- rsp_err  out  1  watchdog abort flag, qualified by rsp_valid
- busy  out  1  high in every state except IDLE
- mul_start  out  1  start pulse to multiplier
- mul_inbus  out  WIDTH  operand bus to multiplier
- mul_ready  in  1  multiplier idle and able to accept start
- mul_done  in  1  multiplier product valid
- mul_result  in  2*WIDTH  multiplier product

Behaviour:
- Reset (rst=0, asynchronous):
  - FSM to IDLE; round-robin pointer to 0.
  - Operand, index and result registers cleared; watchdog counter cleared.
  - All outputs 0.
  - Reset mid-job abandons the job: no rsp_valid is issued and nothing is remembered afterwards.
- FSM states: IDLE, START, LOADY, WAIT, RESP.
- IDLE:
  - If any req=1 and mul_ready=1, choose winner = first asserted req at or after pointer (cyclic).
  - Latch opa/opb slices and the winner index; go to START.
  - If mul_ready=0, stay in IDLE regardless of req.
- START (1 cycle):
  - gnt[winner]=1, mul_start=1, mul_inbus=latched X.
  - Pointer <= winner+1 mod NREQ; go to LOADY.
- LOADY (1 cycle): mul_inbus=latched Y; go to WAIT.
- WAIT:
  - mul_inbus=0.
  - On mul_done=1, capture mul_result and go to RESP.
- RESP (1 cycle):
  - rsp_valid[winner]=1, rsp_data=captured product; go to IDLE.
- Latency: req sampled in IDLE -> gnt 1 cycle later -> rsp_valid 1 cycle after the cycle mul_done is seen.
- Requester contract:
  - Hold req and operands stable until gnt. Operands may change after gnt.
  - req still high after rsp_valid counts as a new request; it competes normally in the next IDLE.
  - Deasserting req before gnt withdraws the request without side effects.
- mul_done outside WAIT is ignored.
- mul_done in the same cycle WAIT is entered is accepted.
- With a single requester active, it is served back to back: one idle cycle between RESP and the next START.
- Outputs are registered from the FSM state, so no combinational path from req to gnt.
- Products are two's complement; rsp_data is passed through unmodified.

Optional Feature:
- Macro: BOOTH_ARB_TIMEOUT_EN.
- When defined:
  - A 16-bit counter clears on entry to WAIT and increments each WAIT cycle.
  - When it reaches TMO_CYCLES without mul_done, go to RESP with rsp_err=1 and rsp_data=0.
  - The pointer has already advanced.
- When not defined:
  - No counter; WAIT persists until mul_done.
  - rsp_err is tied to 0.

Test Plan:
- Single request: req[0], opa0=3, opb0=5 -> gnt[0] pulse, mul_inbus=3 then 5, mul_result=0x00F -> rsp_valid[0] with rsp_data=0x00F, rsp_err=0.
- Signed product: req[2], opa2=5'b11101 (-3), opb2=7 -> rsp_valid[2] with rsp_data=0x3EB (-21).
- Round-robin: all four req held high -> grants 0,1,2,3,0 in order, exactly one rsp_valid per grant to the matching index.
- Multiplier not ready: mul_ready=0 with req[1]=1 for 10 cycles -> no gnt and busy=0; raise mul_ready -> gnt[1] the next cycle.
- Reset mid-job: rst=0 while in WAIT -> all outputs 0 immediately. After release with no req -> no rsp_valid; next request is served from pointer 0.
- With BOOTH_ARB_TIMEOUT_EN, TMO_CYCLES=8, mul_done never asserted -> rsp_valid after 8 WAIT cycles, rsp_err=1, rsp_data=0; the next requester is then served normally.
